// File: rtl/coco3_ps2_pkg.sv
// coco3_ps2_pkg: shared constants, FSM state and event type for the PS/2 key serializer
package coco3_ps2_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int KEY_TOGGLE = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT = 8;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, LOAD_NEXT} ps2_state_t;
  typedef struct packed {
    logic pressed;
    logic ext;
    logic [7:0] code;
  } ps2_event_t;
  function automatic logic [9:0] ps2_tail(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO that accepts a push while full when a pop occurs in the same cycle
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: buffers MiSTer key events and sends them as PS/2 device-side frames
module ps2_key_serializer import coco3_ps2_pkg::*; #(
  parameter int PS2DIV = 1000,
  parameter int GAP_TICKS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        ps2_kbd_clk_out,
  output logic        ps2_kbd_data_out,
  output logic        busy,
  output logic        overflow
);
  localparam int DW = $clog2(PS2DIV);
  localparam int GW = $clog2(GAP_TICKS) + 1;
  logic [10:0] key_q;
  logic key_vld, primed, prev_tog, ev, full, empty, pop, tick, low, brk;
  ps2_event_t head;
  ps2_state_t state;
  logic [DW-1:0] div;
  logic [GW-1:0] gap;
  logic [3:0] bit_idx;
  logic [9:0] frame;
  logic [15:0] rest, rest0;
  logic [7:0] first;
  logic [1:0] left, nleft;
  assign ev = primed && (key_q[KEY_TOGGLE] != prev_tog);
  assign pop = state == LOAD;
  assign tick = div == DW'(PS2DIV - 1);
  assign busy = state != IDLE || !empty;
  assign brk = !head.pressed;
  assign first = head.ext ? PS2_PREFIX_EXT : brk ? PS2_PREFIX_BRK : head.code;
  assign rest0 = head.ext && brk ? {head.code, PS2_PREFIX_BRK} : {8'h00, head.code};
  assign nleft = {1'b0, head.ext} + {1'b0, brk};
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(ps2_event_t))) u_fifo (
    .clk(clk_sys),
    .rst(reset),
    .push(ev),
    .pop(pop),
    .din({key_q[KEY_PRESSED], key_q[KEY_EXT], key_q[7:0]}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      key_q <= '0;
      key_vld <= 1'b0;
      primed <= 1'b0;
      prev_tog <= 1'b0;
      overflow <= 1'b0;
      state <= IDLE;
      div <= '0;
      gap <= '0;
      bit_idx <= '0;
      low <= 1'b0;
      frame <= '1;
      rest <= '0;
      left <= '0;
      ps2_kbd_clk_out <= 1'b1;
      ps2_kbd_data_out <= 1'b1;
    end else begin
      key_q <= ps2_key;
      key_vld <= 1'b1;
      primed <= key_vld;
      prev_tog <= key_q[KEY_TOGGLE];
      if (ev && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD, LOAD_NEXT: begin
          frame <= ps2_tail(state == LOAD ? first : rest[7:0]);
          rest <= state == LOAD ? rest0 : rest >> 8;
          left <= state == LOAD ? nleft : left - 2'd1;
          bit_idx <= '0;
          low <= 1'b0;
          div <= '0;
          ps2_kbd_data_out <= 1'b0;
          state <= SEND;
        end
        SEND: begin
          div <= tick ? '0 : div + DW'(1);
          if (tick) begin
            low <= !low;
            ps2_kbd_clk_out <= low;
            if (low && bit_idx == 4'd10) begin
              gap <= '0;
              state <= GAP;
            end else if (low) begin
              bit_idx <= bit_idx + 4'd1;
              ps2_kbd_data_out <= frame[0];
              frame <= {1'b1, frame[9:1]};
            end
          end
        end
        GAP: begin
          div <= tick ? '0 : div + DW'(1);
          if (tick) begin
            gap <= gap + GW'(1);
            if (gap == GW'(GAP_TICKS - 1)) state <= left != 2'd0 ? LOAD_NEXT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
